// File: rtl/conway_engine_param.sv
// conway_engine_param: toroidal Game-of-Life engine, one row per cycle, atomic commit.
// Optional macro GOL_RULE_CFG_EN adds birth_mask/survive_mask rule ports.
module conway_engine_param #(
   parameter int GRID_W = 40,
   parameter int GRID_H = 30,
   parameter int CUR_W = 8,
   parameter int GEN_W = 16,
   parameter int POP_W = 11
) (
   input logic clk,
   input logic rst,
   input logic step,
   input logic freeze,
   input logic clear,
   input logic draw,
   input logic [CUR_W-1:0] cursor_x,
   input logic [CUR_W-1:0] cursor_y,
   input logic [0:63] pattern_mat,
`ifdef GOL_RULE_CFG_EN
   input logic [8:0] birth_mask,
   input logic [8:0] survive_mask,
`endif
   output logic [0:GRID_W*GRID_H-1] state,
   output logic busy,
   output logic done,
   output logic [GEN_W-1:0] gen_count,
   output logic [POP_W-1:0] population,
   output logic stable
);
   localparam int N = GRID_W * GRID_H;
   localparam int RW = $clog2(GRID_H);
   typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} fsm_t;
   fsm_t fsm;
   logic [RW-1:0] r;
   logic [0:N-1] shadow, stamped;
   logic [POP_W-1:0] pop_acc, row_pop, stamp_pop;
   logic diff, draw_q, draw_pend, row_diff;
   logic [0:GRID_W-1] row_next;
   logic [3:0] nb;
   logic [8:0] bmask, smask;
`ifndef GOL_RULE_CFG_EN
   assign bmask = 9'b000001000;
   assign smask = 9'b000001100;
`endif
   // next value of row r, read only from the committed grid
   always_comb begin
      row_next = '0;
      row_pop = '0;
      row_diff = 1'b0;
      nb = '0;
      for (int x = 0; x < GRID_W; x++) begin
         nb = '0;
         for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
               if (dy != 0 || dx != 0)
                  nb += 4'(state[((int'(r) + dy + GRID_H) % GRID_H) * GRID_W + (x + dx + GRID_W) % GRID_W]);
         row_next[x] = state[int'(r) * GRID_W + x] ? smask[nb] : bmask[nb];
         row_pop += POP_W'(row_next[x]);
         row_diff |= row_next[x] != state[int'(r) * GRID_W + x];
      end
   end
   // OR-only stamp; an out-of-range cursor leaves the grid untouched
   always_comb begin
      stamped = state;
      stamp_pop = '0;
      if (int'(cursor_x) < GRID_W && int'(cursor_y) < GRID_H)
         for (int dy = 0; dy < 8; dy++)
            for (int dx = 0; dx < 8; dx++)
               if (pattern_mat[dy * 8 + dx])
                  stamped[((int'(cursor_y) + dy) % GRID_H) * GRID_W + (int'(cursor_x) + dx) % GRID_W] = 1'b1;
      for (int i = 0; i < N; i++) stamp_pop += POP_W'(stamped[i]);
   end
   always_ff @(posedge clk)
      if (fsm == COMPUTE)
         for (int x = 0; x < GRID_W; x++) shadow[int'(r) * GRID_W + x] <= row_next[x];
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm <= IDLE;
         r <= '0;
         pop_acc <= '0;
         diff <= 1'b0;
         draw_q <= 1'b0;
         draw_pend <= 1'b0;
         state <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         gen_count <= '0;
         population <= '0;
         stable <= 1'b0;
`ifdef GOL_RULE_CFG_EN
         bmask <= '0;
         smask <= '0;
`endif
      end else begin
         draw_q <= draw;
         done <= 1'b0;
         case (fsm)
            IDLE:
               if (clear) begin
                  state <= '0;
                  gen_count <= '0;
                  population <= '0;
                  stable <= 1'b0;
                  draw_pend <= 1'b0;
               end else if (draw_pend) begin
                  state <= stamped;
                  population <= stamp_pop;
                  draw_pend <= 1'b0;
               end else if (step && !freeze) begin
                  fsm <= COMPUTE;
                  r <= '0;
                  pop_acc <= '0;
                  diff <= 1'b0;
                  busy <= 1'b1;
`ifdef GOL_RULE_CFG_EN
                  bmask <= birth_mask;
                  smask <= survive_mask;
`endif
               end
            COMPUTE: begin
               pop_acc <= pop_acc + row_pop;
               diff <= diff | row_diff;
               r <= r + 1'b1;
               if (r == RW'(GRID_H - 1)) fsm <= COMMIT;
            end
            COMMIT: begin
               state <= shadow;
               population <= pop_acc;
               stable <= !diff;
               gen_count <= gen_count + 1'b1;
               done <= 1'b1;
               busy <= 1'b0;
               fsm <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
         if (draw && !draw_q) draw_pend <= 1'b1;
      end
   end
endmodule

// File: tb/tb_conway_engine_param.sv
// tb_conway_engine_param: random and directed checks against an array-based Life model.
module tb_conway_engine_param;
   localparam int W = 40;
   localparam int H = 30;
   localparam int N = W * H;
   logic clk = 1'b0;
   logic rst, step, freeze, clear, draw;
   logic [7:0] cursor_x, cursor_y;
   logic [0:63] pattern_mat;
   logic [0:N-1] state;
   logic busy, done, stable;
   logic [15:0] gen_count;
   logic [10:0] population;
`ifdef GOL_RULE_CFG_EN
   logic [8:0] birth_mask, survive_mask;
`endif
   int n_cmp = 0, n_bad = 0;
   bit m [H][W];
   int m_gen, m_pop;
   bit m_stable;
   logic [8:0] bm = 9'b000001000, sm = 9'b000001100;

   always #5 clk = ~clk;

   conway_engine_param dut (
      .clk(clk), .rst(rst), .step(step), .freeze(freeze), .clear(clear), .draw(draw),
      .cursor_x(cursor_x), .cursor_y(cursor_y), .pattern_mat(pattern_mat),
`ifdef GOL_RULE_CFG_EN
      .birth_mask(birth_mask), .survive_mask(survive_mask),
`endif
      .state(state), .busy(busy), .done(done), .gen_count(gen_count),
      .population(population), .stable(stable)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_pop();
      m_pop = 0;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) m_pop += int'(m[y][x]);
   endtask

   task automatic model_clear();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) m[y][x] = 1'b0;
      m_pop = 0;
      m_gen = 0;
      m_stable = 1'b0;
   endtask

   task automatic model_stamp(input int cx, input int cy, input logic [0:63] p);
      if (cx < W && cy < H)
         for (int dy = 0; dy < 8; dy++)
            for (int dx = 0; dx < 8; dx++)
               if (p[dy * 8 + dx]) m[(cy + dy) % H][(cx + dx) % W] = 1'b1;
      model_pop();
   endtask

   task automatic model_step();
      bit nx [H][W];
      int n;
      m_stable = 1'b1;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            n = 0;
            for (int dy = -1; dy <= 1; dy++)
               for (int dx = -1; dx <= 1; dx++)
                  if (dy != 0 || dx != 0) n += int'(m[(y + dy + H) % H][(x + dx + W) % W]);
            nx[y][x] = m[y][x] ? sm[n] : bm[n];
            if (nx[y][x] != m[y][x]) m_stable = 1'b0;
         end
      m = nx;
      m_gen = (m_gen + 1) % 65536;
      model_pop();
   endtask

   task automatic check_grid(input string tag);
      logic [0:W-1] er;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) er[x] = m[y][x];
         chk(tag, 64'(state[y * W +: W]), 64'(er));
      end
      chk({tag, "_pop"}, 64'(population), 64'(m_pop));
      chk({tag, "_gen"}, 64'(gen_count), 64'(m_gen));
   endtask

   task automatic do_stamp(input int cx, input int cy, input logic [0:63] p);
      cursor_x = 8'(cx);
      cursor_y = 8'(cy);
      pattern_mat = p;
      draw = 1'b1;
      cyc();
      draw = 1'b0;
      cyc();
      model_stamp(cx, cy, p);
      check_grid("stamp");
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      model_clear();
      check_grid("clear");
      chk("clear_stable", 64'(stable), 64'(0));
   endtask

   // with pulse_draw, three draw pulses land mid-COMPUTE and must collapse into one stamp
   task automatic do_step(input string tag, input bit pulse_draw);
      logic [0:N-1] snap;
      int lat;
      bit moved;
      step = 1'b1;
      cyc();
      step = 1'b0;
      chk({tag, "_busy"}, 64'(busy), 64'(1));
      snap = state;
      lat = 0;
      moved = 1'b0;
      while (!done && lat < 100) begin
         if (state !== snap) moved = 1'b1;
         draw = pulse_draw && (lat == 3 || lat == 5 || lat == 7);
         cyc();
         lat++;
      end
      draw = 1'b0;
      chk({tag, "_lat"}, 64'(lat), 64'(H + 1));
      chk({tag, "_hold"}, 64'(moved), 64'(0));
      chk({tag, "_busy0"}, 64'(busy), 64'(0));
      model_step();
      check_grid(tag);
      chk({tag, "_stable"}, 64'(stable), 64'(m_stable));
      if (pulse_draw) begin
         cyc();
         model_stamp(int'(cursor_x), int'(cursor_y), pattern_mat);
         check_grid("late_stamp");
         cyc();
         check_grid("one_stamp");
      end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      logic [0:63] p;
      bit bad_busy, bad_gen;
      rst = 1'b1; step = 1'b0; freeze = 1'b0; clear = 1'b0; draw = 1'b0;
      cursor_x = '0; cursor_y = '0; pattern_mat = '0;
`ifdef GOL_RULE_CFG_EN
      birth_mask = bm;
      survive_mask = sm;
`endif
      cyc();
      cyc();
      rst = 1'b0;
      model_clear();
      check_grid("reset");
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_done", 64'(done), 64'(0));
      chk("reset_stable", 64'(stable), 64'(0));
      p = '0; p[0] = 1'b1; p[1] = 1'b1; p[2] = 1'b1;
      do_stamp(5, 5, p);
      do_step("blink1", 1'b0);
      do_step("blink2", 1'b0);
      do_clear();
      p = '0; p[0] = 1'b1; p[8] = 1'b1; p[16] = 1'b1;
      do_stamp(0, 29, p);
      do_step("wrap", 1'b0);
      do_clear();
      p = '0; p[0] = 1'b1; p[1] = 1'b1; p[8] = 1'b1; p[9] = 1'b1;
      do_stamp(10, 10, p);
      do_step("block", 1'b0);
      p = '0; p[0] = 1'b1;
      cursor_x = 8'd20;
      cursor_y = 8'd20;
      pattern_mat = p;
      do_step("busydraw", 1'b1);
      freeze = 1'b1;
      step = 1'b1;
      bad_busy = 1'b0;
      bad_gen = 1'b0;
      repeat (100) begin
         cyc();
         if (busy !== 1'b0) bad_busy = 1'b1;
         if (gen_count !== 16'(m_gen)) bad_gen = 1'b1;
      end
      freeze = 1'b0;
      step = 1'b0;
      chk("freeze_busy", 64'(bad_busy), 64'(0));
      chk("freeze_gen", 64'(bad_gen), 64'(0));
      do_clear();
      do_step("empty", 1'b0);
      do_stamp(200, 3, {32'hffff_ffff, 32'hffff_ffff});
      for (int k = 0; k < 5; k++) begin
         if (k % 2 == 0) do_clear();
         repeat (1 + k % 3) do_stamp(int'($urandom_range(0, 45)), int'($urandom_range(0, 33)), {$urandom, $urandom});
         do_step("rand", 1'b0);
         do_step("rand", 1'b0);
      end
`ifdef GOL_RULE_CFG_EN
      do_clear();
      bm = 9'b000000100;
      sm = 9'b000000000;
      birth_mask = bm;
      survive_mask = sm;
      p = '0; p[0] = 1'b1; p[1] = 1'b1;
      do_stamp(3, 3, p);
      do_step("rulecfg", 1'b0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/conway_engine_param.md
Name: conway_engine_param

Overview:
- Parametrised successor to the fixed-size Game-of-Life state machine. Holds a GRID_W x GRID_H toroidal cell grid.
- Advances one generation per accepted step request, computing one row per cycle into a shadow buffer, then commits the whole grid atomically.
- Adds a pending-draw 8x8 pattern stamp, a clear command, a generation counter, population count, stable-grid detection and a busy/done handshake.
- Sits between the input/cursor logic and the VGA/LED renderer, which reads `state`.

Parameters:
- GRID_W, 40, cells per row (>=3)
- GRID_H, 30, rows (>=3)
- CUR_W, 8, cursor coordinate width
- GEN_W, 16, generation counter width
- POP_W, 11, population width; must satisfy 2^POP_W > GRID_W*GRID_H

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- step  in  1  advance-one-generation request (level; accepted in IDLE)
- freeze  in  1  1 = step requests ignored; draw/clear still honoured
- clear  in  1  zero the grid (accepted in IDLE)
- draw  in  1  stamp request; rising edge latched
- cursor_x  in  CUR_W  stamp origin column
- cursor_y  in  CUR_W  stamp origin row
- pattern_mat  in  64 [0:63]  8x8 stamp; bit dy*8+dx
- state  out  GRID_W*GRID_H [0:N-1]  cell (y,x) at bit y*GRID_W+x
- busy  out  1  high from step accept through commit
- done  out  1  one-cycle pulse on the cycle the committed grid first appears on `state`
- gen_count  out  GEN_W  generations committed since reset/clear; wraps
- population  out  POP_W  live cells in current `state`
- stable  out  1  last committed generation equalled its predecessor

Behaviour:
- Reset: all outputs 0, FSM IDLE, draw_pend 0, internal edge register 0. Reset during COMPUTE aborts the generation; the shadow buffer is discarded.
- FSM states: IDLE, COMPUTE, COMMIT.
- IDLE priority, highest first:
  - clear: state, gen_count, population and stable go to 0; draw_pend is dropped.
  - draw_pend: apply the stamp in 1 cycle, set population to the recount of the stamped grid, clear draw_pend, remain in IDLE.
  - step && !freeze: go to COMPUTE with row counter r=0 and pop_acc=0; busy goes to 1 on the next edge.
- draw rising edge sets draw_pend in any state. Several edges while busy collapse to one stamp, applied in the first IDLE cycle after COMMIT.
- Stamp rules:
  - For dx,dy in 0..7, if pattern_mat[dy*8+dx]=1, set cell ((cursor_y+dy) mod GRID_H, (cursor_x+dx) mod GRID_W) to 1.
  - Cells under a 0 bit are unchanged, so the stamp is OR-only.
  - If cursor_x>=GRID_W or cursor_y>=GRID_H, the stamp is dropped and draw_pend is still cleared.
- COMPUTE:
  - Each cycle computes next row r from the frozen `state`.
  - Neighbour count is 8-way, range 0..8 (4 bits), with toroidal wrap: row -1 maps to GRID_H-1, column GRID_W maps to 0, and corners wrap both ways.
  - Rule B3/S23: live cell survives iff n in {2,3}; dead cell is born iff n==3.
  - The row is written to the shadow buffer, its popcount is added to pop_acc, and row inequality is ORed into a diff flag.
  - The cycle with r==GRID_H-1 goes to COMMIT.
- COMMIT (1 cycle), then back to IDLE:
  - state <= shadow
  - population <= pop_acc
  - stable <= !diff
  - gen_count += 1, wrapping at 2^GEN_W
  - done=1 for this single edge; busy=0 after the edge
- Latency: step accepted at edge k gives the new state and done at edge k+GRID_H+1. Throughput is one generation per GRID_H+2 cycles with step held high.
- Inputs while busy:
  - step, clear and freeze are ignored. freeze does not abort an in-flight generation.
  - cursor and pattern are sampled only when the stamp is applied.
- `state` is never modified during COMPUTE.
- Empty grid: step yields an empty grid, population 0, stable=1, and gen_count still increments.

Optional Feature:
- Macro GOL_RULE_CFG_EN.
- Defined:
  - Adds ports birth_mask in 9 and survive_mask in 9.
  - Both are latched on step accept and held for the whole generation.
  - Dead cell with count n is born iff birth_mask[n]; live cell survives iff survive_mask[n].
- Undefined:
  - Ports absent.
  - Rule is hard-wired B3/S23, equivalent to birth_mask=9'b000001000 and survive_mask=9'b000001100.

Test Plan:
- Blinker: rst, stamp pattern bits 0,1,2 (horizontal triple) at cursor (5,5), then step.
  - Required: cells (4,6),(5,6),(6,6) live, population=3, gen_count=1, done at accept+GRID_H+1.
  - Second step restores the horizontal triple; stable=0.
- Wrap: with default 40x30, stamp a vertical triple at cursor (0,29) (bits 0,8,16) and step.
  - Required: row 0 has cells x=39,0,1 live, i.e. the horizontal triple wraps across the edge.
- Block still life: stamp a 2x2 block (bits 0,1,8,9) at (10,10) and step.
  - Required: grid unchanged, stable=1, population=4.
- Draw during busy: raise step; pulse draw 3 times mid-COMPUTE with a single-cell pattern at (20,20).
  - Required: exactly one stamp, applied the cycle after done; the cell set while `state` stays unchanged during COMPUTE.
- Freeze/clear: hold freeze=1 and step=1 for 100 cycles, then assert clear.
  - Required: busy stays 0 and gen_count unchanged throughout; after clear, state=0, population=0, gen_count=0.
- Rule config (GOL_RULE_CFG_EN defined): birth_mask bit 2 only, survive_mask=0, two adjacent live cells.
  - Required: after one step, the originals die and the births are exactly the cells with n==2.
